// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller: per-frame snapshot,
// BCD decode, leading-zero blanking, decimal points and a blanking guard between digits.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        lzb_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;
  logic [3:0]       cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [15:0] snap, input logic [1:0] d);
    case (d)
      2'd3:    lz_blank = (snap[15:12] == 4'd0);
      2'd2:    lz_blank = (snap[15:8] == 8'd0);
      2'd1:    lz_blank = (snap[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_SCAN;
      cnt_d     = '0;
      idx_d     = 2'd0;
      snap_d    = digits;
      snap_dp_d = dp_en;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d    = digits;
        snap_dp_d = dp_en;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are registered from the next slot state so they line up with cnt/idx.
  always_comb begin
    an_d      = 4'b1111;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    tick_d    = 1'b0;
    cur_digit = snap_d[{idx_d, 2'b00} +: 4];
    if (state_d == ST_SCAN && cnt_d >= BLANK_END) begin
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = (lzb_en && lz_blank(snap_d, idx_d)) ? 7'h7F : decode(cur_digit);
      dp_d   = ~snap_dp_d[idx_d];
      tick_d = (cnt_d == CNT_LAST) && (idx_d == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      snap_dp_q <= 4'h0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= 4'b1111;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_sel  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_seg_scan_controller;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        lzb_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_en(dp_en),
    .lzb_en(lzb_en), .seg(seg), .dp(dp), .an(an), .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: running flag plus absolute position within the frame.
  bit          m_run = 0;
  int          m_pos = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_lzb = 1'b0;
  logic [6:0]  lut [16];

  initial begin
    lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30;
    lut[4] = 7'h19; lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78;
    lut[8] = 7'h00; lut[9] = 7'h10;
    for (int i = 10; i < 16; i++) lut[i] = 7'h7F;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_snap = 16'h0; m_dp = 4'h0; m_lzb = 1'b0;
    end else begin
      m_lzb = lzb_en;
      if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_snap = digits; m_dp = dp_en;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0) begin
          m_snap = digits; m_dp = dp_en;
        end
      end
    end
  end

  task automatic model_out(output logic [3:0] e_an, output logic [6:0] e_seg,
                           output logic e_dp, output logic [1:0] e_ds, output logic e_tick);
    int d, c, dig;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ds = 2'd0; e_tick = 1'b0;
    if (m_run) begin
      d = m_pos / RD;
      c = m_pos % RD;
      e_ds = 2'(d);
      if (c >= BL) begin
        dig = int'((m_snap >> (4 * d)) & 16'hF);
        e_an = ~(4'(1) << d);
        if (dig > 9 || (m_lzb && d > 0 && (m_snap >> (4 * d)) == 16'h0)) e_seg = 7'h7F;
        else e_seg = lut[dig];
        e_dp = ~m_dp[d];
        e_tick = (m_pos == FRAME - 1);
      end
    end
  endtask

  // Per-cycle compare plus anode overlap / guard-interval monitor.
  logic [3:0] prev_an = 4'hF;
  int         f_run = 100;
  always @(negedge clk) begin
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic [1:0] e_ds; logic e_tick;
    model_out(e_an, e_seg, e_dp, e_ds, e_tick);
    n_vec++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || digit_sel !== e_ds || frame_tick !== e_tick) begin
      n_err++;
      $display("FAIL model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ds=%0d/%0d tick=%b/%b (got/expected)",
               $time, an, e_an, seg, e_seg, dp, e_dp, digit_sel, e_ds, frame_tick, e_tick);
    end
    n_vec++;
    if ($countones(~an) > 1) begin
      n_err++;
      $display("FAIL overlap t=%0t an=%b required at most one low bit", $time, an);
    end
    if (an !== 4'hF) begin
      if (prev_an === 4'hF) begin
        n_vec++;
        if (f_run < BL) begin
          n_err++;
          $display("FAIL guard t=%0t dark cycles=%0d required >=%0d", $time, f_run, BL);
        end
      end else if (an !== prev_an) begin
        n_vec++; n_err++;
        $display("FAIL guard t=%0t an %b -> %b without dark interval", $time, prev_an, an);
      end
      f_run = 0;
    end else begin
      f_run++;
    end
    prev_an = an;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into cycle 0 of a fresh frame.
  task automatic start_frame();
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; digits = 16'h0; dp_en = 4'h0; lzb_en = 1'b0;
    step(3);
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_seg", 16'(seg), 16'h7F);
    chk("reset_tick", 16'(frame_tick), 16'h0);
    rst_n = 1'b1;
    step(2);

    // basic scan
    digits = 16'h1234;
    start_frame();
    chk("s1_c0_an", 16'(an), 16'hF);
    step(2);  chk("s1_c2_an", 16'(an), 16'hE); chk("s1_c2_seg", 16'(seg), 16'h19);
    step(8);  chk("s1_c10_an", 16'(an), 16'hD); chk("s1_c10_seg", 16'(seg), 16'h30);
    step(8);  chk("s1_c18_an", 16'(an), 16'hB); chk("s1_c18_seg", 16'(seg), 16'h24);
    step(8);  chk("s1_c26_an", 16'(an), 16'h7); chk("s1_c26_seg", 16'(seg), 16'h79);
    chk("s1_c26_tick", 16'(frame_tick), 16'h0);
    step(5);  chk("s1_c31_tick", 16'(frame_tick), 16'h1);
    step(1);  chk("s1_c32_tick", 16'(frame_tick), 16'h0); chk("s1_c32_an", 16'(an), 16'hF);
    step(31); chk("s1_c63_tick", 16'(frame_tick), 16'h1);

    // snapshot holds for the rest of the frame
    start_frame();
    step(12); digits = 16'h5678;
    step(6);  chk("s2_c18_seg", 16'(seg), 16'h24);
    step(8);  chk("s2_c26_seg", 16'(seg), 16'h79);
    step(8);  chk("s2_c34_seg", 16'(seg), 16'h00); chk("s2_c34_an", 16'(an), 16'hE);
    step(8);  chk("s2_c42_seg", 16'(seg), 16'h78);

    // leading-zero blanking
    lzb_en = 1'b1; digits = 16'h0050;
    start_frame();
    step(2);  chk("s3_c2_seg", 16'(seg), 16'h40);
    step(8);  chk("s3_c10_seg", 16'(seg), 16'h12);
    step(8);  chk("s3_c18_seg", 16'(seg), 16'h7F); chk("s3_c18_an", 16'(an), 16'hB);
    step(8);  chk("s3_c26_seg", 16'(seg), 16'h7F); chk("s3_c26_an", 16'(an), 16'h7);
    digits = 16'h0000;
    step(8);  chk("s3_c34_seg", 16'(seg), 16'h40);
    step(8);  chk("s3_c42_seg", 16'(seg), 16'h7F); chk("s3_c42_an", 16'(an), 16'hD);

    // decimal point and invalid code
    lzb_en = 1'b0; dp_en = 4'b0100; digits = 16'hA000;
    start_frame();
    step(2);  chk("s4_c2_dp", 16'(dp), 16'h1); chk("s4_c2_seg", 16'(seg), 16'h40);
    step(14); chk("s4_c16_dp", 16'(dp), 16'h1);
    step(2);  chk("s4_c18_dp", 16'(dp), 16'h0); chk("s4_c18_an", 16'(an), 16'hB);
    step(8);  chk("s4_c26_seg", 16'(seg), 16'h7F); chk("s4_c26_an", 16'(an), 16'h7);
    chk("s4_c26_dp", 16'(dp), 16'h1);

    // disable mid-frame, then reset mid-drive
    dp_en = 4'h0; digits = 16'h1234;
    start_frame();
    step(20); enable = 1'b0;
    step(1);  chk("s5_dis_an", 16'(an), 16'hF); chk("s5_dis_ds", 16'(digit_sel), 16'h0);
    chk("s5_dis_tick", 16'(frame_tick), 16'h0);
    enable = 1'b1;
    step(1);  chk("s5_re_c0_an", 16'(an), 16'hF);
    step(1);  chk("s5_re_c1_an", 16'(an), 16'hF);
    step(1);  chk("s5_re_c2_an", 16'(an), 16'hE);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_an", 16'(an), 16'hF); chk("s5_rst_seg", 16'(seg), 16'h7F);
    chk("s5_rst_dp", 16'(dp), 16'h1);
    step(3);
    rst_n = 1'b1;
    step(2);

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) digits = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) dp_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
